gate_arb: RTL

- Round-robin arbiter and sequencer that shares one W-bit registered bitwise gate unit between two requesters.
- Gate functions: AND, OR, NOT, NAND, NOR, XOR, XNOR.
- Each requester presents an opcode and two operands. The block grants one requester, captures its operands, executes, and holds the tagged result until the consumer accepts it.
- Sits between the two operation sources and the shared result consumer.

---
 rtl/gate_arb.sv | 89 ++++++++
 1 files changed

// File: rtl/gate_arb.sv
// gate_arb: round-robin arbiter sharing one registered W-bit bitwise gate unit between two requesters
// Ports: clk/rst (async active-high); req0/op0/a0/b0 -> gnt0 and req1/op1/a1/b1 -> gnt1 (one-cycle grant pulses);
// res/res_id/res_err qualified by res_vld, released by res_rdy; busy high while a transaction is in flight.
module gate_arb #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req0,
  input  logic [2:0]   op0,
  input  logic [W-1:0] a0,
  input  logic [W-1:0] b0,
  output logic         gnt0,
  input  logic         req1,
  input  logic [2:0]   op1,
  input  logic [W-1:0] a1,
  input  logic [W-1:0] b1,
  output logic         gnt1,
  output logic [W-1:0] res,
  output logic         res_id,
  output logic         res_err,
  output logic         res_vld,
  input  logic         res_rdy,
  output logic         busy
);
  typedef enum logic [1:0] {IDLE, EXEC, HOLD} state_t;
  state_t       state;
  logic         last;
  logic         pick;
  logic [2:0]   op_r;
  logic [W-1:0] a_r;
  logic [W-1:0] b_r;
  logic [W-1:0] res_n;
  // last doubles as the id of the transaction in flight, since it is loaded with the winner at grant
  always_comb begin
    pick  = (req0 & req1) ? ~last : req1;
    res_n = op_r == 3'd0 ? a_r & b_r :
            op_r == 3'd1 ? a_r | b_r :
            op_r == 3'd2 ? ~a_r :
            op_r == 3'd3 ? ~(a_r & b_r) :
            op_r == 3'd4 ? ~(a_r | b_r) :
            op_r == 3'd5 ? a_r ^ b_r :
            op_r == 3'd6 ? ~(a_r ^ b_r) : '0;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      last    <= 1'b1;
      op_r    <= '0;
      a_r     <= '0;
      b_r     <= '0;
      gnt0    <= 1'b0;
      gnt1    <= 1'b0;
      res     <= '0;
      res_id  <= 1'b0;
      res_err <= 1'b0;
      res_vld <= 1'b0;
      busy    <= 1'b0;
    end else begin
      gnt0 <= 1'b0;
      gnt1 <= 1'b0;
      case (state)
        IDLE: if (req0 | req1) begin
          state <= EXEC;
          busy  <= 1'b1;
          last  <= pick;
          op_r  <= pick ? op1 : op0;
          a_r   <= pick ? a1 : a0;
          b_r   <= pick ? b1 : b0;
          gnt0  <= ~pick;
          gnt1  <= pick;
        end
        EXEC: begin
          res     <= res_n;
          res_id  <= last;
          res_err <= &op_r;
          res_vld <= 1'b1;
          state   <= HOLD;
        end
        HOLD: if (res_rdy) begin
          res_vld <= 1'b0;
          busy    <= 1'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
